// File: rtl/cu_pkg.sv
// Shared definitions for the cu_sequencer control unit: opcodes, HALT word,
// FSM state encoding and instruction field positions.
package cu_pkg;

  localparam int unsigned XLEN   = 12;
  localparam int unsigned RA_W   = 3;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned OPC_W  = 3;

  localparam int unsigned OPC_LSB = 9;
  localparam int unsigned RD_LSB  = 6;
  localparam int unsigned RS1_LSB = 3;
  localparam int unsigned RS2_LSB = 0;

  localparam logic [XLEN-1:0] HALT_WORD = 12'h000;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_UMUL = 3'b011,
    OP_SMUL = 3'b100,
    OP_FADD = 3'b101,
    OP_FMUL = 3'b110,
    OP_CMP  = 3'b111
  } cu_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } cu_state_e;

  function automatic logic [OPC_W-1:0] f_opc(input logic [XLEN-1:0] w);
    return w[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [RA_W-1:0] f_rd(input logic [XLEN-1:0] w);
    return w[RD_LSB +: RA_W];
  endfunction

  function automatic logic [RA_W-1:0] f_rs1(input logic [XLEN-1:0] w);
    return w[RS1_LSB +: RA_W];
  endfunction

  function automatic logic [RA_W-1:0] f_rs2(input logic [XLEN-1:0] w);
    return w[RS2_LSB +: RA_W];
  endfunction

endpackage

// File: rtl/cu_regfile.sv
// 8x12 register file: one synchronous write port, two operand read ports
// and one debug read port, all reads combinational.
module cu_regfile
  import cu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RA_W-1:0] ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [RA_W-1:0] ra2,
  output logic [XLEN-1:0] rd2,
  input  logic [RA_W-1:0] ra3,
  output logic [XLEN-1:0] rd3
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];
  assign rd3 = regs_q[ra3];

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer feeding a 12-bit ALU.
// Optional retired-instruction counter enabled by defining CU_RETIRE_CNT_EN.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned PC_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_data,
  input  logic             ld_en,
  input  logic [RA_W-1:0]  ld_addr,
  input  logic [XLEN-1:0]  ld_data,
  input  logic [RA_W-1:0]  rd_addr,
  output logic [XLEN-1:0]  rd_data,
  output logic [OPC_W-1:0] alu_opcode,
  output logic [XLEN-1:0]  alu_op1,
  output logic [XLEN-1:0]  alu_op2,
  input  logic [XLEN-1:0]  alu_result
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [15:0]      retired
`endif
);

  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  cu_state_e        state_q;
  logic [PC_W-1:0]  pc_q;
  logic [RA_W-1:0]  rd_q;
  logic [XLEN-1:0]  res_q;
  logic [CNT_W-1:0] cnt_q;

  logic             rf_we;
  logic [RA_W-1:0]  rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic [XLEN-1:0]  rf_rd1;
  logic [XLEN-1:0]  rf_rd2;

  // Host loads only land in IDLE; WB owns the write port otherwise.
  assign rf_we    = ((state_q == S_IDLE) && ld_en) || (state_q == S_WB);
  assign rf_waddr = (state_q == S_WB) ? rd_q  : ld_addr;
  assign rf_wdata = (state_q == S_WB) ? res_q : ld_data;

  cu_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .ra1   (f_rs1(imem_data)),
    .rd1   (rf_rd1),
    .ra2   (f_rs2(imem_data)),
    .rd2   (rf_rd2),
    .ra3   (rd_addr),
    .rd3   (rd_data)
  );

  // imem_addr is loaded on every transition into FETCH so the ROM word is
  // valid throughout DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      rd_q       <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      imem_addr  <= '0;
      alu_opcode <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
`ifdef CU_RETIRE_CNT_EN
      retired    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q      <= '0;
            imem_addr <= '0;
            busy      <= 1'b1;
            state_q   <= S_FETCH;
`ifdef CU_RETIRE_CNT_EN
            retired   <= '0;
`endif
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (imem_data == HALT_WORD) begin
            done    <= 1'b1;
            state_q <= S_DONE;
          end else if (f_opc(imem_data) == OP_NOP) begin
            pc_q      <= pc_q + PC_W'(1);
            imem_addr <= pc_q + PC_W'(1);
            state_q   <= S_FETCH;
`ifdef CU_RETIRE_CNT_EN
            if (retired != 16'hFFFF) retired <= retired + 16'd1;
`endif
          end else begin
            alu_opcode <= f_opc(imem_data);
            alu_op1    <= rf_rd1;
            alu_op2    <= rf_rd2;
            rd_q       <= f_rd(imem_data);
            cnt_q      <= '0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q == CNT_W'(ALU_LAT - 1)) begin
            res_q   <= alu_result;
            state_q <= S_WB;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          pc_q      <= pc_q + PC_W'(1);
          imem_addr <= pc_q + PC_W'(1);
          state_q   <= S_FETCH;
`ifdef CU_RETIRE_CNT_EN
          if (retired != 16'hFFFF) retired <= retired + 16'd1;
`endif
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed vector table, hand-written
// corner sequences and randomized programs against a program-level model.
module tb_cu_sequencer;

  localparam int LAT = 1;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  imem_addr;
  logic [11:0] imem_data;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [11:0] ld_data;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;
  logic [2:0]  alu_opcode;
  logic [11:0] alu_op1;
  logic [11:0] alu_op2;
  logic [11:0] alu_result;
`ifdef CU_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  logic [11:0] rom    [256];
  logic [11:0] m_regs [8];
  logic [2:0]  cap_opc;
  logic [11:0] cap_op1;
  logic [11:0] cap_op2;
  int n_cmp;
  int n_bad;

  cu_sequencer #(.ALU_LAT(LAT), .PC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .alu_opcode (alu_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
`ifdef CU_RETIRE_CNT_EN
    .retired    (retired),
`endif
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction ROM, one-cycle read latency.
  always @(posedge clk) imem_data <= rom[imem_addr];

  // Stand-in ALU; only the pass-through matters to the sequencer.
  function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [11:0] a,
                                         input logic [11:0] b);
    logic [23:0] p;
    logic signed [23:0] sp;
    logic [12:0] s;
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: begin p = a * b; return p[11:0]; end
      3'd4: begin sp = $signed(a) * $signed(b); return sp[11:0]; end
      3'd5: begin s = {1'b0, a} + {1'b0, b}; return s[12:1]; end
      3'd6: return a ^ {b[5:0], b[11:6]};
      3'd7: return (a < b) ? 12'hFFF : ((a == b) ? 12'h000 : 12'h001);
      default: return 12'h000;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_op1, alu_op2);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Program-level model: walks the ROM, updates m_regs, returns done cycle.
  task automatic model_exec(output int dcyc, output int ret);
    int pc;
    int cyc;
    logic [11:0] w;
    logic [2:0] op;
    pc = 0; cyc = 0; dcyc = -2; ret = 0;
    for (int s = 0; s < 2000; s++) begin
      w = rom[pc];
      if (w == 12'h000) begin
        dcyc = cyc + 3;
        break;
      end
      op = w[11:9];
      if (op == 3'b000) begin
        cyc += 2;
      end else begin
        m_regs[w[8:6]] = alu_fn(op, m_regs[w[5:3]], m_regs[w[2:0]]);
        cyc += 3 + LAT;
      end
      ret++;
      pc = (pc + 1) % 256;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; ld_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 12'h000;
  endtask

  task automatic load_reg(input logic [2:0] a, input logic [11:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk($sformatf("%s R%0d", tag, i), int'(rd_data), int'(m_regs[i]));
    end
  endtask

  // Pulses start (optionally with a same-cycle load), waits for done.
  task automatic run_prog(input string tag, input int exp_cyc, input int exp_ret,
                          input logic ld_same, input logic [2:0] la, input logic [11:0] ldd,
                          input int patch_k, input int patch_a, input logic [11:0] patch_v);
    int got;
    got = -1;
    @(negedge clk);
    start = 1'b1; ld_en = ld_same; ld_addr = la; ld_data = ldd;
    @(posedge clk); #1;
    start = 1'b0; ld_en = 1'b0;
    for (int k = 1; k <= exp_cyc + 20; k++) begin
      @(negedge clk);
      if (k == patch_k) rom[patch_a] = patch_v;
      if (k == 3) begin cap_opc = alu_opcode; cap_op1 = alu_op1; cap_op2 = alu_op2; end
      if (done) begin got = k; break; end
    end
    chk({tag, " done cycle"}, got, exp_cyc);
    if (got > 0) begin
      chk({tag, " busy in DONE"}, int'(busy), 1);
      @(negedge clk);
      chk({tag, " done one-shot"}, int'(done), 0);
      chk({tag, " busy idle"}, int'(busy), 0);
    end
`ifdef CU_RETIRE_CNT_EN
    chk({tag, " retired"}, int'(retired), exp_ret);
`else
    if (exp_ret < 0) chk({tag, " retired arg"}, exp_ret, 0);
`endif
  endtask

  typedef struct {
    logic [11:0] r1, r2, i0, i1;
    int          cyc;
    logic [11:0] r3;
    logic [2:0]  opc;
    logic [11:0] op1, op2;
  } vec_t;

  initial begin
    vec_t vt [6];
    int dcyc, ret, got;
    logic seen;
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    imem_data = '0;
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;

    vt[0] = '{12'h040, 12'h001, 12'h2CA, 12'h000, 7, 12'h041, 3'b001, 12'h040, 12'h001};
    vt[1] = '{12'h040, 12'h001, 12'h4CA, 12'h000, 7, 12'h03F, 3'b010, 12'h040, 12'h001};
    vt[2] = '{12'h040, 12'h001, 12'h001, 12'h000, 5, 12'h000, 3'b000, 12'h000, 12'h000};
    vt[3] = '{12'h040, 12'h001, 12'h000, 12'h2CA, 3, 12'h000, 3'b000, 12'h000, 12'h000};
    vt[4] = '{12'h000, 12'h001, 12'h4CA, 12'h000, 7, 12'hFFF, 3'b010, 12'h000, 12'h001};
    vt[5] = '{12'h040, 12'h041, 12'h6CA, 12'h000, 7, 12'h040, 3'b011, 12'h040, 12'h041};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst imem_addr", int'(imem_addr), 0);
    chk("rst alu_opcode", int'(alu_opcode), 0);
    chk("rst alu_op1", int'(alu_op1), 0);
    chk("rst alu_op2", int'(alu_op2), 0);
    check_regs("rst");

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      do_reset();
      load_reg(3'd1, vt[v].r1);
      load_reg(3'd2, vt[v].r2);
      rom[0] = vt[v].i0; rom[1] = vt[v].i1;
      run_prog($sformatf("vec%0d", v), vt[v].cyc, (vt[v].i0 == 12'h000) ? 0 : 1,
               1'b0, 3'd0, 12'h000, -1, 0, 12'h000);
      chk($sformatf("vec%0d alu_opcode", v), int'(cap_opc), int'(vt[v].opc));
      chk($sformatf("vec%0d alu_op1", v), int'(cap_op1), int'(vt[v].op1));
      chk($sformatf("vec%0d alu_op2", v), int'(cap_op2), int'(vt[v].op2));
      m_regs[3] = vt[v].r3;
      check_regs($sformatf("vec%0d", v));
    end

    // Reset during EXEC of ADD r1,r1,r2
    do_reset();
    load_reg(3'd1, 12'h005);
    load_reg(3'd2, 12'h007);
    rom[0] = 12'h24A; rom[1] = 12'h000;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rstexec in EXEC opcode", int'(alu_opcode), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    chk("rstexec busy", int'(busy), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rstexec no done", int'(seen), 0);
    for (int i = 0; i < 8; i++) m_regs[i] = 12'h000;
    check_regs("rstexec");

    // start + ld_en in the same IDLE cycle, CMP r1,r1,r2
    do_reset();
    load_reg(3'd2, 12'h005);
    rom[0] = 12'hE4A; rom[1] = 12'h000;
    m_regs[1] = 12'h003;
    model_exec(dcyc, ret);
    run_prog("ldstart", dcyc, ret, 1'b1, 3'd1, 12'h003, -1, 0, 12'h000);
    chk("ldstart alu_op1", int'(cap_op1), 12'h003);
    chk("ldstart R1 const", int'(m_regs[1]), 12'hFFF);
    check_regs("ldstart");

    // start and ld_en during EXEC are ignored
    do_reset();
    load_reg(3'd1, 12'h040);
    load_reg(3'd2, 12'h001);
    rom[0] = 12'h2CA; rom[1] = 12'h000;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    start = 1'b1; ld_en = 1'b1; ld_addr = 3'd5; ld_data = 12'hABC;
    @(posedge clk); #1 start = 1'b0; ld_en = 1'b0;
    got = -1;
    for (int k = 4; k < 30; k++) begin
      @(negedge clk);
      if (done) begin got = k; break; end
    end
    chk("busyld done cycle", got, 7);
    m_regs[3] = 12'h041;
    check_regs("busyld");
    @(negedge clk); @(negedge clk);
    chk("busyld stays idle", int'(busy), 0);

    // PC wrap: NOP sweep, ADD at 255, wrap to 0, HALT patched into ROM[1]
    do_reset();
    load_reg(3'd1, 12'h010);
    load_reg(3'd2, 12'h003);
    for (int i = 0; i < 255; i++) rom[i] = 12'h001;
    rom[255] = 12'h24A;
    run_prog("wrap", 519, 257, 1'b0, 3'd0, 12'h000, 10, 1, 12'h000);
    m_regs[1] = 12'h013;
    check_regs("wrap");

    // Randomized programs against the model
    for (int it = 0; it < 15; it++) begin
      int len;
      do_reset();
      for (int r = 0; r < 8; r++) load_reg(3'(r), 12'($urandom));
      len = $urandom_range(3, 10);
      for (int i = 0; i < 256; i++) rom[i] = 12'h000;
      for (int i = 0; i < len; i++) begin
        rom[i] = 12'($urandom);
        if (rom[i] == 12'h000) rom[i] = 12'h001;
      end
      model_exec(dcyc, ret);
      run_prog($sformatf("rnd%0d", it), dcyc, ret, 1'b0, 3'd0, 12'h000, -1, 0, 12'h000);
      check_regs($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
